// File: rtl/pe_rr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : pe_rr_encoder
//  Description : Registered N-input priority encoder with a selectable
//                round-robin mode and a valid/ready output handshake.
//
//  Ports
//    wb_clk_i  in   1   clock, all state on the rising edge
//    wb_rst_i  in   1   asynchronous active-high reset
//    en_i      in   1   encoder enable
//    mode_i    in   1   0 = fixed priority (highest index), 1 = round-robin
//    req_i     in   N   request vector, bit i = channel i
//    ready_i   in   1   consumer accepts the current result
//    valid_o   out  1   idx_o holds a granted channel
//    idx_o     out  W   granted channel index
//    gs_o      out  1   a request was present at the last load
//    eno_o     out  1   enabled and no request present at the last load
//
//  Revision    : 1.0  initial release
// ============================================================================
module pe_rr_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         en_i,
    input  logic         mode_i,
    input  logic [N-1:0] req_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o,
    output logic         gs_o,
    output logic         eno_o
);

    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_gs;
    logic         r_eno;
    logic [W-1:0] r_ptr;     // channel currently holding top priority

    logic         w_load;
    logic         w_any;
    logic [W-1:0] w_fix_idx;
    logic [W-1:0] w_rr_idx;
    logic [W-1:0] w_rr_cand;
    logic         w_rr_found;
    logic [W-1:0] w_grant;
    logic [W-1:0] w_ptr_next;

    // A new result may enter whenever the output register is empty or is
    // being consumed on this edge, which gives back-to-back transfers.
    assign w_load = ~r_valid | ready_i;
    assign w_any  = |req_i;

    // Fixed priority: the last set bit seen in an ascending scan is the
    // highest one.
    always_comb begin
        w_fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                w_fix_idx = W'(i);
            end
        end
    end

    // Round-robin: scan downward from the pointer. N is a power of two, so
    // W-bit subtraction wraps 0 -> N-1 on its own.
    always_comb begin
        w_rr_idx   = '0;
        w_rr_cand  = '0;
        w_rr_found = 1'b0;
        for (int off = 0; off < N; off++) begin
            w_rr_cand = r_ptr - W'(off);
            if (!w_rr_found && req_i[w_rr_cand]) begin
                w_rr_idx   = w_rr_cand;
                w_rr_found = 1'b1;
            end
        end
    end

    assign w_grant    = mode_i ? w_rr_idx : w_fix_idx;
    // The granted channel drops to lowest priority: the one just below it
    // becomes the new top.
    assign w_ptr_next = w_grant - W'(1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_gs    <= 1'b0;
            r_eno   <= 1'b0;
            r_ptr   <= W'(N - 1);
        end else if (w_load) begin
            if (!en_i) begin
                r_valid <= 1'b0;
                r_gs    <= 1'b0;
                r_eno   <= 1'b0;
            end else if (!w_any) begin
                r_valid <= 1'b0;
                r_gs    <= 1'b0;
                r_eno   <= 1'b1;
            end else begin
                r_valid <= 1'b1;
                r_gs    <= 1'b1;
                r_eno   <= 1'b0;
                r_idx   <= w_grant;
                if (mode_i) begin
                    r_ptr <= w_ptr_next;
                end
            end
        end
    end

    assign valid_o = r_valid;
    assign idx_o   = r_idx;
    assign gs_o    = r_gs;
    assign eno_o   = r_eno;

endmodule
`default_nettype wire
